// File: rtl/booth_acc.sv
// booth_acc: accumulates a programmed count of signed Booth products, counting each rising edge of prod_valid once.
// Optional macro BOOTH_ACC_SAT_EN: saturate on signed overflow instead of wrapping.
module booth_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [CNT_WIDTH-1:0]   i_len,
  input  logic                   i_prod_valid,
  input  logic [2*WIDTH-1:0]     i_prod,
  output logic                   o_busy,
  output logic                   o_acc_valid,
  output logic [ACC_WIDTH-1:0]   o_acc_out,
  output logic                   o_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_pv_q;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_ovf;
  logic                  r_busy;
  logic                  r_acc_valid;

  logic                  w_edge;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_add_ovf;
  logic [ACC_WIDTH-1:0]  w_acc_next;

  // A multiplier may hold done for several cycles; only its rising edge is a new product.
  assign w_edge     = i_prod_valid & ~r_pv_q;
  assign w_prod_ext = ACC_WIDTH'($signed(i_prod));
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

`ifdef BOOTH_ACC_SAT_EN
  // Operands share a sign on overflow, so the accumulator sign picks the rail.
  assign w_acc_next = !w_add_ovf ? w_sum :
                      r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign w_acc_next = w_sum;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pv_q      <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_pv_q <= i_prod_valid;
      if (i_start) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= i_len;
        if (i_len == '0) begin
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
          r_acc_valid <= 1'b1;
        end else begin
          r_state     <= S_ACCUM;
          r_busy      <= 1'b1;
          r_acc_valid <= 1'b0;
        end
      end else begin
        case (r_state)
          S_ACCUM: begin
            if (w_edge) begin
              r_acc <= w_acc_next;
              r_ovf <= r_ovf | w_add_ovf;
              r_cnt <= r_cnt - CNT_WIDTH'(1);
              if (r_cnt == CNT_WIDTH'(1)) begin
                r_state     <= S_DONE;
                r_busy      <= 1'b0;
                r_acc_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_acc_valid = r_acc_valid;
  assign o_acc_out   = r_acc;
  assign o_ovf       = r_ovf;

endmodule
